// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: funct3 codes,
// FSM state encoding and the signed-overflow dividend.
package ex_muldiv_pkg;

  // funct3 encodings of the M-extension ops
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // Most negative 32-bit value; DIV/REM of this by -1 overflows
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: one shift-add multiply bit or one restoring divide bit
// per step, sharing a single 2*DATA_WIDTH accumulator. For multiply the
// accumulator is {product_hi, multiplier/product_lo}; for divide it is
// {remainder, dividend/quotient}. Sign-corrected views of the post-step value
// are exported so the controller can capture them on the final edge.
module muldiv_iter_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic                    i_step,
  input  logic                    i_op_is_div,
  input  logic [DATA_WIDTH-1:0]   i_a,
  input  logic [DATA_WIDTH-1:0]   i_b,
  input  logic                    i_neg_prod,
  input  logic                    i_neg_quot,
  input  logic                    i_neg_rem,
  output logic [2*DATA_WIDTH-1:0] o_prod_fin,
  output logic [DATA_WIDTH-1:0]   o_quot_fin,
  output logic [DATA_WIDTH-1:0]   o_rem_fin
);

  localparam int DW = DATA_WIDTH;

  logic [2*DW-1:0] r_acc;
  logic [DW-1:0]   r_b;

  logic [DW:0]     w_mul_sum;
  logic [2*DW-1:0] w_mul_nxt;
  logic [DW:0]     w_div_sh;
  logic [DW:0]     w_div_diff;
  logic [2*DW-1:0] w_div_nxt;
  logic [2*DW-1:0] w_acc_nxt;

  // One iteration of multiply and divide; the op selects which one commits
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    w_mul_sum  = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_mul_nxt  = {w_mul_sum, r_acc[DW-1:1]};
    w_div_sh   = r_acc[2*DW-1:DW-1];
    w_div_diff = w_div_sh - {1'b0, r_b};
    if (w_div_diff[DW]) begin
      w_div_nxt = {w_div_sh[DW-1:0], r_acc[DW-2:0], 1'b0};
    end else begin
      w_div_nxt = {w_div_diff[DW-1:0], r_acc[DW-2:0], 1'b1};
    end
    w_acc_nxt  = i_op_is_div ? w_div_nxt : w_mul_nxt;
    o_prod_fin = i_neg_prod ? -w_acc_nxt : w_acc_nxt;
    o_quot_fin = i_neg_quot ? -w_acc_nxt[DW-1:0] : w_acc_nxt[DW-1:0];
    o_rem_fin  = i_neg_rem ? -w_acc_nxt[2*DW-1:DW] : w_acc_nxt[2*DW-1:DW];
  end

  // Accumulator and divisor/multiplicand register
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      r_acc <= '0;
      r_b   <= '0;
    end else if (i_load) begin
      r_acc <= {{DW{1'b0}}, i_a};
      r_b   <= i_b;
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage M-extension sequencer: accepts an M-op, stalls the pipeline while
// the iterative core runs DATA_WIDTH steps (or takes the divide fast path),
// then presents the result for one md_done cycle.
module ex_muldiv_ctrl
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  md_valid_EX,
  input  logic [2:0]            md_op_EX,
  input  logic [DATA_WIDTH-1:0] rs1_val_EX,
  input  logic [DATA_WIDTH-1:0] rs2_val_EX,
  input  logic                  flush_EX,
  output logic                  md_stall,
  output logic                  md_done,
  output logic [DATA_WIDTH-1:0] md_res
);

  localparam int DW = DATA_WIDTH;

  md_state_e            r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2:0]           r_op;
  logic                 r_neg_a, r_neg_b;
  logic [DW-1:0]        r_res;

  logic                 w_accept, w_last, w_step;
  logic                 w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic [DW-1:0]        w_mag_a, w_mag_b;
  logic                 w_div0, w_ovf, w_fast;
  logic [DW-1:0]        w_fast_res, w_calc_res;
  logic [2*DW-1:0]      w_prod_fin;
  logic [DW-1:0]        w_quot_fin, w_rem_fin;

  // Operand decode at accept: signedness, magnitudes and fast-path results
  always_comb begin
    w_accept   = (r_state == ST_IDLE) && md_valid_EX && !flush_EX;
    w_sgn_a    = (md_op_EX == MD_MULH) || (md_op_EX == MD_MULHSU) ||
                 (md_op_EX == MD_DIV)  || (md_op_EX == MD_REM);
    w_sgn_b    = (md_op_EX == MD_MULH) || (md_op_EX == MD_DIV) || (md_op_EX == MD_REM);
    w_neg_a    = w_sgn_a && rs1_val_EX[DW-1];
    w_neg_b    = w_sgn_b && rs2_val_EX[DW-1];
    w_mag_a    = w_neg_a ? -rs1_val_EX : rs1_val_EX;
    w_mag_b    = w_neg_b ? -rs2_val_EX : rs2_val_EX;
    w_div0     = md_op_EX[2] && (rs2_val_EX == '0);
    w_ovf      = ((md_op_EX == MD_DIV) || (md_op_EX == MD_REM)) &&
                 (rs1_val_EX == DW'(DIV_OVF_DIVIDEND)) && (rs2_val_EX == '1);
    w_fast     = w_div0 || w_ovf;
    w_fast_res = '0;
    if (w_div0) begin
      w_fast_res = md_op_EX[1] ? rs1_val_EX : '1;
    end else if (w_ovf) begin
      w_fast_res = md_op_EX[1] ? '0 : DW'(DIV_OVF_DIVIDEND);
    end
    w_last     = (r_state == ST_CALC) && (r_cnt == CNT_WIDTH'(DW - 1));
    w_step     = (r_state == ST_CALC) && !flush_EX;
  end

  // Result select from the sign-corrected core outputs
  always_comb begin
    w_calc_res = '0;
    case (r_op)
      MD_MUL:                        w_calc_res = w_prod_fin[DW-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  w_calc_res = w_prod_fin[2*DW-1:DW];
      MD_DIV, MD_DIVU:               w_calc_res = w_quot_fin;
      MD_REM, MD_REMU:               w_calc_res = w_rem_fin;
      default:                       w_calc_res = '0;
    endcase
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    md_stall    = md_valid_EX && !flush_EX && (r_state != ST_DONE);
    md_done     = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_fast ? ST_DONE : ST_CALC;
      ST_CALC: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        md_done     = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush_EX) begin
      w_state_nxt = ST_IDLE;
      md_done     = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Op/sign capture, iteration counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (w_accept) begin
      r_op    <= md_op_EX;
      r_neg_a <= w_neg_a;
      r_neg_b <= w_neg_b;
      r_cnt   <= '0;
      if (w_fast) r_res <= w_fast_res;
    end else if (w_step) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_res <= w_calc_res;
    end
  end

  assign md_res = r_res;

  muldiv_iter_core #(.DATA_WIDTH(DW)) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_step     (w_step),
    .i_op_is_div(r_op[2]),
    .i_a        (w_mag_a),
    .i_b        (w_mag_b),
    .i_neg_prod (r_neg_a ^ r_neg_b),
    .i_neg_quot (r_neg_a ^ r_neg_b),
    .i_neg_rem  (r_neg_a),
    .o_prod_fin (w_prod_fin),
    .o_quot_fin (w_quot_fin),
    .o_rem_fin  (w_rem_fin)
  );

  // The pipeline must keep the M-op in EX for the whole calculation
  a_valid_held: assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_CALC) |-> (md_valid_EX || flush_EX));

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed self-checking bench for ex_muldiv_ctrl: multiply/divide results,
// stall length, fast paths, flush, reset mid-calculation and back-to-back ops.
module tb_ex_muldiv_ctrl;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_valid_EX;
  logic [2:0]  md_op_EX;
  logic [31:0] rs1_val_EX, rs2_val_EX;
  logic        flush_EX;
  logic        md_stall, md_done;
  logic [31:0] md_res;

  int checks   = 0;
  int failures = 0;

  ex_muldiv_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .md_valid_EX(md_valid_EX),
    .md_op_EX   (md_op_EX),
    .rs1_val_EX (rs1_val_EX),
    .rs2_val_EX (rs2_val_EX),
    .flush_EX   (flush_EX),
    .md_stall   (md_stall),
    .md_done    (md_done),
    .md_res     (md_res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one M-op, count stall cycles up to md_done and check the result.
  // Operands are scrambled mid-calculation to show they are sampled at accept.
  // Returns just after the DONE edge with md_valid_EX still high.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall);
    int stalls = 0;
    bit seen   = 0;
    md_valid_EX = 1'b1;
    md_op_EX    = op;
    rs1_val_EX  = a;
    rs2_val_EX  = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (md_done) begin
        seen = 1'b1;
        break;
      end
      if (md_stall) stalls++;
      @(posedge clk);
      #1;
      if (i == 2) begin
        rs1_val_EX = ~a;
        rs2_val_EX = a ^ b ^ 32'h5A5A_0001;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_res"}, md_res, exp_res);
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    check({tag, "_stall_in_done"}, 32'(md_stall), 32'd0);
    tick(1);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; md_valid_EX = 1'b0; md_op_EX = MD_MUL;
    rs1_val_EX = '0; rs2_val_EX = '0; flush_EX = 1'b0;
    tick(2);
    @(negedge clk);
    check("reset_done", 32'(md_done), 32'd0);
    check("reset_res", md_res, 32'd0);
    check("reset_stall", 32'(md_stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(1);

    // Multiply family
    run_op("mul_7_m3", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    md_valid_EX = 1'b0;
    @(negedge clk);
    check("mul_done_one_cycle", 32'(md_done), 32'd0);
    check("mul_res_hold", md_res, 32'hFFFF_FFEB);
    @(posedge clk); #1;
    run_op("mulhu_ff", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulh_ff", MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("mulhsu_ff", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

    // Divide family
    run_op("div_m20_3", MD_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
    run_op("rem_m20_3", MD_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
    run_op("divu_20_3", MD_DIVU, 32'd20, 32'd3, 32'd6, 33);
    run_op("remu_20_3", MD_REMU, 32'd20, 32'd3, 32'd2, 33);

    // Fast paths: divide by zero and signed overflow
    run_op("divu_by0", MD_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", MD_REMU, 32'd5, 32'd0, 32'd5, 1);
    run_op("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    md_valid_EX = 1'b0;
    tick(1);

    // Flush in CALC cycle 10: no md_done, result register untouched
    md_valid_EX = 1'b1; md_op_EX = MD_DIV;
    rs1_val_EX = 32'hFFFF_FFEC; rs2_val_EX = 32'd3;
    tick(11);
    flush_EX = 1'b1;
    @(negedge clk);
    check("flush_stall_low", 32'(md_stall), 32'd0);
    @(posedge clk); #1;
    flush_EX = 1'b0; md_valid_EX = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_done) pulses++;
    end
    check("flush_no_done", 32'(pulses), 32'd0);
    check("flush_res_hold", md_res, 32'h8000_0000);
    @(posedge clk); #1;
    run_op("after_flush_mul", MD_MUL, 32'd11, 32'd13, 32'd143, 33);

    // Reset mid-CALC
    md_op_EX = MD_DIV; rs1_val_EX = 32'd100; rs2_val_EX = 32'd7;
    tick(11);
    rst = 1'b1; md_valid_EX = 1'b0;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_res", md_res, 32'd0);
    check("midrst_done", 32'(md_done), 32'd0);
    check("midrst_stall", 32'(md_stall), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    @(posedge clk); #1;

    // Back-to-back MULs: second accepted in the cycle after DONE
    run_op("b2b_mul_2x3", MD_MUL, 32'd2, 32'd3, 32'd6, 33);
    run_op("b2b_mul_4x5", MD_MUL, 32'd4, 32'd5, 32'd20, 33);
    md_valid_EX = 1'b0;
    tick(1);

    // Flush coinciding with DONE masks md_done
    md_valid_EX = 1'b1; md_op_EX = MD_MUL;
    rs1_val_EX = 32'd9; rs2_val_EX = 32'd9;
    tick(33);
    flush_EX = 1'b1;
    @(negedge clk);
    check("flush_done_masked", 32'(md_done), 32'd0);
    check("flush_done_stall", 32'(md_stall), 32'd0);
    check("flush_done_res", md_res, 32'd81);
    @(posedge clk); #1;
    flush_EX = 1'b0; md_valid_EX = 1'b0;
    @(negedge clk);
    check("flush_done_after", 32'(md_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
